// File: rtl/banked_ram_pkg.sv
// Shared FSM encoding and width helpers for the banked RAM controller.
package banked_ram_pkg;

  typedef logic [0:0] state_t;

  localparam state_t CLEAR = 1'b0;
  localparam state_t READY = 1'b1;

  function automatic int calc_bank_w(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int calc_word_w(input int bank_depth);
    return $clog2(bank_depth);
  endfunction

endpackage

// File: rtl/ram_bank.sv
// One RAM bank: synchronous write, read-first registered output.
// The output register has a synchronous reset so it can map onto a block-RAM output register.
module ram_bank #(
  parameter int DATA_W     = 8,
  parameter int BANK_DEPTH = 8,
  localparam int WORD_W    = $clog2(BANK_DEPTH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic              re,
  input  logic [WORD_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [BANK_DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Output only moves on a read, so an idle bank keeps presenting its last result.
  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/banked_ram_ctrl.sv
// Single-port RAM built from NUM_BANKS banks with a valid/ready request port
// and a clear sweep that zeroes every word after reset.
module banked_ram_ctrl
  import banked_ram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BANK_DEPTH = 8,
  parameter int NUM_BANKS  = 2,
  localparam int BANK_W    = calc_bank_w(NUM_BANKS),
  localparam int WORD_W    = calc_word_w(BANK_DEPTH),
  localparam int ADDR_W    = BANK_W + WORD_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              rd_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  state_t            state_reg;
  logic [WORD_W-1:0] clr_ptr_reg;
  logic [BANK_W-1:0] bank_sel_reg;
  logic              rd_valid_reg;

  logic [BANK_W-1:0] req_bank;
  logic [WORD_W-1:0] req_word;
  logic              accept;
  logic              wr_accept;
  logic              rd_accept;
  logic              sweep_we;
  logic [WORD_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

  assign req_bank = addr[ADDR_W-1 -: BANK_W];
  assign req_word = addr[WORD_W-1:0];

  // Reset wins over a request presented on the same edge.
  assign accept    = req_valid && (state_reg == READY) && !clr;
  assign wr_accept = accept && rw;
  assign rd_accept = accept && !rw;
  assign sweep_we  = (state_reg == CLEAR) && !clr;

  assign bank_addr  = (state_reg == CLEAR) ? clr_ptr_reg : req_word;
  assign bank_wdata = (state_reg == CLEAR) ? '0 : data_in;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic bank_hit;
      assign bank_hit = (req_bank == BANK_W'(gi));

      ram_bank #(
        .DATA_W     (DATA_W),
        .BANK_DEPTH (BANK_DEPTH)
      ) u_bank (
        .clk   (clk),
        .srst  (clr),
        .we    (sweep_we || (wr_accept && bank_hit)),
        .re    (rd_accept && bank_hit),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= CLEAR;
      clr_ptr_reg  <= '0;
      rd_valid_reg <= 1'b0;
      bank_sel_reg <= '0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) begin
        bank_sel_reg <= req_bank;
      end
      case (state_reg)
        CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + 1'b1;
          if (clr_ptr_reg == WORD_W'(BANK_DEPTH - 1)) begin
            state_reg <= READY;
          end
        end
        default: begin
          state_reg <= READY;
        end
      endcase
    end
  end

  assign busy      = (state_reg == CLEAR);
  assign req_ready = (state_reg == READY);
  assign rd_valid  = rd_valid_reg;
  assign data_out  = bank_rdata[bank_sel_reg];

endmodule

// File: tb/tb_banked_ram_ctrl.sv
// Scoreboard bench for banked_ram_ctrl: reads push expected data, the monitor pops on rd_valid.
module tb_banked_ram_ctrl;

  localparam int DATA_W     = 8;
  localparam int BANK_DEPTH = 8;
  localparam int NUM_BANKS  = 2;
  localparam int ADDR_W     = 4;
  localparam int WORDS      = BANK_DEPTH * NUM_BANKS;

  logic              clk = 1'b0;
  logic              clr;
  logic              req_valid;
  logic              req_ready;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              rd_valid;
  logic [DATA_W-1:0] data_out;
  logic              busy;

  banked_ram_ctrl #(
    .DATA_W     (DATA_W),
    .BANK_DEPTH (BANK_DEPTH),
    .NUM_BANKS  (NUM_BANKS)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rw        (rw),
    .addr      (addr),
    .data_in   (data_in),
    .rd_valid  (rd_valid),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [WORDS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding read, one cycle after issue.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rd  addr=%0d data=0x%02h exp=0x%02h cycle=%0d", e.a, data_out, e.data, cyc);
        check_eq("rd_data", 32'(data_out), 32'(e.data));
        check_eq("rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic model_zero();
    for (int i = 0; i < WORDS; i++) model[i] = '0;
  endtask

  // Drives one request for one cycle; only used while the RAM is READY.
  task automatic do_req(input logic is_wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    rw        = is_wr;
    addr      = a;
    data_in   = d;
    if (is_wr) begin
      model[a] = d;
      $display("wr  addr=%0d data=0x%02h cycle=%0d", a, d, cyc);
    end else begin
      e.a    = a;
      e.data = model[a];
      e.due  = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // Called at a negedge with clr just released; counts cycles until req_ready.
  task automatic sweep_wait(input logic hold_wr);
    int n;
    n         = 0;
    req_valid = hold_wr;
    rw        = 1'b1;
    addr      = 4'd2;
    data_in   = 8'h33;
    while (req_ready !== 1'b1 && n < 50) begin
      if (busy !== 1'b1) check_eq("busy_in_sweep", 32'(busy), 32'd1);
      n++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check_eq("sweep_len", 32'(n), 32'(BANK_DEPTH));
    check_eq("busy_after_sweep", 32'(busy), 32'd0);
    model_zero();
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    clr       = 1'b1;
    req_valid = 1'b0;
    rw        = 1'b0;
    addr      = '0;
    data_in   = '0;
    model_zero();
    repeat (2) @(negedge clk);

    // 1: sweep length and all-zero contents
    clr_pulse();
    sweep_wait(1'b0);
    for (int a = 0; a < WORDS; a++) do_req(1'b0, ADDR_W'(a), '0);
    idle();
    drain();

    // 2: one write per bank, reads in both orders
    do_req(1'b1, 4'd3, 8'hA5);
    do_req(1'b1, 4'd11, 8'h5A);
    do_req(1'b0, 4'd3, '0);
    do_req(1'b0, 4'd11, '0);
    do_req(1'b0, 4'd11, '0);
    do_req(1'b0, 4'd3, '0);
    idle();
    drain();

    // 3: fill with addr*0x11, then 16 back-to-back reads
    for (int a = 0; a < WORDS; a++) do_req(1'b1, ADDR_W'(a), DATA_W'(a * 8'h11));
    for (int a = 0; a < WORDS; a++) do_req(1'b0, ADDR_W'(a), '0);
    idle();
    drain();

    // 4: write then immediate read of the same word
    do_req(1'b1, 4'd7, 8'hFF);
    do_req(1'b0, 4'd7, '0);
    idle();
    drain();

    // 5: writes during the sweep are dropped; clr mid-sweep restarts it
    clr_pulse();
    req_valid = 1'b1;
    rw        = 1'b1;
    addr      = 4'd2;
    data_in   = 8'h33;
    repeat (4) @(negedge clk);
    clr       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("restart_busy", 32'(busy), 32'd1);
    clr = 1'b0;
    sweep_wait(1'b1);
    do_req(1'b0, 4'd2, '0);
    idle();
    drain();

    // 6: clr on the edge of a read suppresses it and zeroes data_out
    do_req(1'b1, 4'd5, 8'h77);
    do_req(1'b0, 4'd5, '0);
    idle();
    drain();
    check_eq("data_out_hold", 32'(data_out), 32'h77);
    @(negedge clk);
    req_valid = 1'b1;
    rw        = 1'b0;
    addr      = 4'd5;
    clr       = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("clr_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("clr_data_out", 32'(data_out), 32'd0);
    clr = 1'b0;
    sweep_wait(1'b0);
    do_req(1'b0, 4'd5, '0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
